// File: rtl/uart_tx_mmio_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio_pkg
//  Brief    : Register offsets, STATUS bit positions and TX FSM state encoding
//             shared by the memory-mapped UART transmitter.
//  Revision : 1.0
// ============================================================================
package uart_tx_mmio_pkg;

    localparam logic [1:0] c_off_txdata = 2'd0;
    localparam logic [1:0] c_off_status = 2'd1;
    localparam logic [1:0] c_off_count  = 2'd2;
    localparam logic [1:0] c_off_rsvd   = 2'd3;

    localparam int c_st_busy  = 0;
    localparam int c_st_full  = 1;
    localparam int c_st_empty = 2;
    localparam int c_st_ovf   = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic logic [7:0] status_byte(input logic ovf, input logic empty,
                                               input logic full, input logic busy);
        logic [7:0] s;
        s             = 8'h00;
        s[c_st_ovf]   = ovf;
        s[c_st_empty] = empty;
        s[c_st_full]  = full;
        s[c_st_busy]  = busy;
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_mmio_if.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio_if
//  Brief    : CPU-side 8-bit data / 16-bit address bus seen by the UART.
//  Revision : 1.0
// ============================================================================
interface uart_tx_mmio_if;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  di;
    logic [7:0]  dout;

    modport master (output addr, output we, output di, input dout);
    modport slave  (input addr, input we, input di, output dout);
endinterface
`default_nettype wire

// File: rtl/uart_tx_mmio_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio_sync_fifo
//  Brief    : Show-ahead synchronous FIFO; extra pointer bit separates full
//             from empty at wrap-around. A push into a full FIFO is accepted
//             only when a pop happens on the same edge.
//  Revision : 1.0
// ============================================================================
module uart_tx_mmio_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  wire logic                     clk,
    input  wire logic                     rst,
    input  wire logic                     push,
    input  wire logic [WIDTH-1:0]         din,
    input  wire logic                     pop,
    output logic      [WIDTH-1:0]         dout,
    output logic                          full,
    output logic                          empty,
    output logic      [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wptr_q, wptr_d, rptr_q, rptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             w_do_pop, w_do_push;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign count = wptr_q - rptr_q;
    assign dout  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        w_do_pop  = pop && !empty;
        w_do_push = push && (!full || w_do_pop);
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        mem_d     = mem_q;
        if (w_do_push) begin
            mem_d[wptr_q[AW-1:0]] = din;
            wptr_d                = wptr_q + {{AW{1'b0}}, 1'b1};
        end
        if (w_do_pop) begin
            rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage needs no reset: pointers alone define which entries are valid.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule
`default_nettype wire

// File: rtl/uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : uart_tx_mmio
//  Brief    : Memory-mapped 8N1 UART transmitter with a small TX FIFO.
//  Revision : 1.0
// ============================================================================
module uart_tx_mmio
    import uart_tx_mmio_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR    = 16'hFF00,
    parameter int          CLKS_PER_BIT = 4,
    parameter int          FIFO_DEPTH   = 4
) (
    input  wire logic       clk,
    input  wire logic       rst,
    uart_tx_mmio_if.slave   bus,
    output logic            tx,
    output logic            busy
);
    localparam int                BAUD_W      = $clog2(CLKS_PER_BIT);
    localparam int                CNT_W       = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BAUD_W-1:0] C_BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shreg_q, shreg_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic [7:0]        dout_q, dout_d;

    logic              w_sel, w_push, w_pop, w_clr, w_drop, w_baud_end;
    logic [1:0]        w_off;
    logic [7:0]        w_fifo_dout;
    logic              w_fifo_full, w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;

    uart_tx_mmio_sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .din   (bus.di),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    assign w_sel    = (bus.addr[15:2] == BASE_ADDR[15:2]);
    assign w_off    = bus.addr[1:0];
    assign w_push   = w_sel && bus.we && (w_off == c_off_txdata);
    assign w_clr    = w_sel && bus.we && (w_off == c_off_status) && bus.di[c_st_ovf];
    assign w_drop   = w_push && w_fifo_full && !w_pop;
    assign busy     = (state_q != ST_IDLE) || !w_fifo_empty;
    assign tx       = tx_q;
    assign bus.dout = dout_q;

    always_comb begin
        state_d    = state_q;
        baud_d     = baud_q;
        bit_d      = bit_q;
        shreg_d    = shreg_q;
        w_pop      = 1'b0;
        w_baud_end = (baud_q == C_BAUD_LAST);
        if (state_q != ST_IDLE) begin
            baud_d = w_baud_end ? '0 : baud_q + {{(BAUD_W-1){1'b0}}, 1'b1};
        end
        case (state_q)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop   = 1'b1;
                    shreg_d = w_fifo_dout;
                    baud_d  = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (w_baud_end) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (w_baud_end) begin
                    shreg_d = {1'b0, shreg_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            default: begin
                // Back-to-back frames: reload straight from the FIFO, no idle bit.
                if (w_baud_end) begin
                    if (!w_fifo_empty) begin
                        w_pop   = 1'b1;
                        shreg_d = w_fifo_dout;
                        state_d = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
        endcase
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = shreg_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    always_comb begin
        ovf_d  = w_drop ? 1'b1 : (w_clr ? 1'b0 : ovf_q);
        dout_d = 8'h00;
        if (w_sel && !bus.we) begin
            case (w_off)
                c_off_status: dout_d = status_byte(ovf_q, w_fifo_empty, w_fifo_full, busy);
                c_off_count:  dout_d = 8'(w_fifo_count);
                c_off_rsvd:   dout_d = 8'h00;
                default:      dout_d = 8'h00;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shreg_q <= 8'h00;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
            dout_q  <= 8'h00;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
            dout_q  <= dout_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_mmio.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_tx_mmio
//  Brief    : Scoreboard bench: a transaction-level model predicts frames,
//             read data and busy; a serial monitor decodes tx at bit centres.
//  Revision : 1.0
// ============================================================================
module tb_uart_tx_mmio;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 4;
    localparam int          FRAME = 10 * CPB;
    localparam logic [15:0] BASE  = 16'hFF00;

    logic clk = 1'b0;
    logic rst;
    logic tx, busy;

    uart_tx_mmio_if bus ();

    uart_tx_mmio #(
        .BASE_ADDR    (BASE),
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus),
        .tx   (tx),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue, transmitter as "free again at edge m_idle_at".
    logic [7:0] m_fifo[$];
    logic [7:0] exp_frames[$];
    int         cyc       = 0;
    int         m_idle_at = 0;
    bit         m_ovf     = 1'b0;
    logic [7:0] exp_do    = 8'h00;
    bit         exp_busy  = 1'b0;
    bit         started   = 1'b0;
    bit         abort     = 1'b0;

    always @(posedge clk) begin
        logic [15:0] base_v;
        logic [1:0]  off;
        bit          sel, pop, push_ok, drop, clr, eng_busy;
        cyc++;
        base_v = BASE;
        if (rst) begin
            m_fifo.delete();
            exp_frames.delete();
            m_idle_at = cyc;
            m_ovf     = 1'b0;
            exp_do    = 8'h00;
            exp_busy  = 1'b0;
            abort     = 1'b1;
            started   = 1'b1;
        end else begin
            sel      = (bus.addr[15:2] == base_v[15:2]);
            off      = bus.addr[1:0];
            eng_busy = (cyc <= m_idle_at);
            exp_do   = 8'h00;
            if (sel && !bus.we) begin
                if (off == 2'd1)
                    exp_do = {4'b0, m_ovf, m_fifo.size() == 0, m_fifo.size() == DEPTH,
                              eng_busy || (m_fifo.size() != 0)};
                else if (off == 2'd2)
                    exp_do = 8'(m_fifo.size());
            end
            pop     = (m_fifo.size() != 0) && (cyc >= m_idle_at);
            push_ok = 1'b0;
            drop    = 1'b0;
            clr     = sel && bus.we && (off == 2'd1) && bus.di[3];
            if (sel && bus.we && off == 2'd0) begin
                if (m_fifo.size() < DEPTH || pop) push_ok = 1'b1;
                else                              drop    = 1'b1;
            end
            m_ovf = drop ? 1'b1 : (clr ? 1'b0 : m_ovf);
            if (pop) begin
                exp_frames.push_back(m_fifo.pop_front());
                m_idle_at = cyc + FRAME;
            end
            if (push_ok) m_fifo.push_back(bus.di);
            exp_busy = (cyc + 1 <= m_idle_at) || (m_fifo.size() != 0);
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("do", bus.dout, exp_do);
            chk("busy", busy, exp_busy);
        end
    end

    // Serial monitor: start bit seen at n0, bit centres at n0+2, n0+6+4k, n0+38.
    initial begin
        logic [7:0] b;
        logic       s0, sp;
        forever begin
            @(negedge clk);
            if (started && tx === 1'b0) begin
                abort = 1'b0;
                repeat (CPB / 2) @(negedge clk);
                s0 = tx;
                for (int k = 0; k < 8; k++) begin
                    repeat (CPB) @(negedge clk);
                    b[k] = tx;
                end
                repeat (CPB) @(negedge clk);
                sp = tx;
                if (!abort) begin
                    if (exp_frames.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL frame_unexpected: got %0h expected no frame", b);
                    end else begin
                        chk("frame_data", b, exp_frames.pop_front());
                        chk("start_bit", s0, 1'b0);
                        chk("stop_bit", sp, 1'b1);
                    end
                end
            end
        end
    end

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 1'b1;
        bus.di   = d;
    endtask

    task automatic rd_chk(input string nm, input logic [15:0] a, input logic [7:0] e);
        @(negedge clk);
        bus.addr = a;
        bus.we   = 1'b0;
        @(negedge clk);
        bus.addr = 16'h0000;
        chk(nm, bus.dout, e);
    endtask

    task automatic wait_idle(output int n);
        @(negedge clk);
        bus.addr = 16'h0000;
        bus.we   = 1'b0;
        n = 1;
        while (busy !== 1'b0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 2000) begin
            n_checks++;
            n_fail++;
            $display("FAIL idle_timeout: busy still %b after %0d cycles, required 0", busy, n);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       txs [1:60];
        logic       bzs [1:60];
        logic [7:0] pat;
        int         n, fall;
        int         r;

        rst      = 1'b1;
        bus.addr = 16'h0000;
        bus.we   = 1'b0;
        bus.di   = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // 1. reset state
        @(negedge clk);
        chk("rst_tx", tx, 1'b1);
        chk("rst_do", bus.dout, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rd_chk("rst_status", BASE + 16'd1, 8'h04);

        // 2. single frame timing
        pat = 8'h55;
        wr(BASE, pat);
        @(negedge clk);
        bus.addr = 16'h0000;
        bus.we   = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            if (k > 1) @(negedge clk);
            txs[k] = tx;
            bzs[k] = busy;
        end
        fall = 0;
        for (int k = 60; k >= 1; k--) if (bzs[k] === 1'b1 && fall == 0) fall = k + 1;
        chk("t2_pre_start", txs[1], 1'b1);
        chk("t2_start_first", txs[2], 1'b0);
        chk("t2_start_last", txs[5], 1'b0);
        for (int i = 0; i < 8; i++) chk("t2_data_bit", txs[7 + CPB * i], pat[i]);
        chk("t2_stop_first", txs[38], 1'b1);
        chk("t2_stop_last", txs[41], 1'b1);
        chk("t2_busy_fall", fall, 42);

        // 3. five back-to-back writes, no idle gap
        for (int i = 0; i < 5; i++) wr(BASE, 8'hA1 + 8'(i));
        wait_idle(n);
        chk("t3_duration", n, 198);
        rd_chk("t3_status", BASE + 16'd1, 8'h04);

        // 4. overflow and clear
        for (int i = 0; i < 6; i++) wr(BASE, 8'($urandom));
        rd_chk("t4_status_ovf", BASE + 16'd1, 8'h0B);
        wr(BASE + 16'd1, 8'h08);
        rd_chk("t4_status_clr", BASE + 16'd1, 8'h03);
        wait_idle(n);
        rd_chk("t4_status_end", BASE + 16'd1, 8'h04);

        // 5. reset mid-frame
        wr(BASE, 8'hC3);
        wr(BASE, 8'h3C);
        @(negedge clk);
        bus.we = 1'b0;
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_tx", tx, 1'b1);
        chk("t5_busy", busy, 1'b0);
        rd_chk("t5_count", BASE + 16'd2, 8'h00);
        repeat (50) @(negedge clk);

        // 6. address decode boundaries
        rd_chk("t6_rd_feff", 16'hFEFF, 8'h00);
        rd_chk("t6_rd_0000", 16'h0000, 8'h00);
        rd_chk("t6_rd_ff03", BASE + 16'd3, 8'h00);
        wr(16'hFF04, 8'h77);
        wr(BASE + 16'd2, 8'h66);
        @(negedge clk);
        bus.we   = 1'b0;
        bus.addr = 16'h0000;
        chk("t6_busy", busy, 1'b0);
        rd_chk("t6_count", BASE + 16'd2, 8'h00);

        // Randomised traffic, checked by the model every cycle
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            if (r <= 4) begin
                wr(BASE, 8'($urandom));
            end else if (r == 5 || r == 6) begin
                @(negedge clk);
                bus.we   = 1'b0;
                bus.addr = BASE + 16'(r - 4);
            end else if (r == 7) begin
                wr(BASE + 16'd1, 8'($urandom));
            end else if (r == 8) begin
                @(negedge clk);
                bus.we   = 1'($urandom);
                bus.di   = 8'($urandom);
                bus.addr = ($urandom_range(0, 1) == 0) ? 16'hFEFF : 16'hFF04;
            end else begin
                @(negedge clk);
                bus.we   = 1'b0;
                bus.addr = 16'h0000;
                repeat ($urandom_range(0, 30)) @(negedge clk);
            end
        end
        wait_idle(n);
        repeat (FRAME) @(negedge clk);
        chk("frames_pending", exp_frames.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
